fifo_stream_packetizer: RTL and testbench

- Drains the read port of a synchronous first-word-fall-through FIFO and presents the data as an AXI-stream master.
- Frames the stream into packets. TLAST is asserted after a programmable beat count, or when the FIFO runs dry for a programmable idle timeout.
- Sits at the read end of a data FIFO, feeding stream sinks such as DMA or stream-to-bus bridges.

---
 rtl/fifo_stream_packetizer_pkg.sv | 16 +
 rtl/fifo_stream_timer.sv | 33 +++
 rtl/fifo_stream_packetizer.sv | 173 +++++++++++++++++
 tb/tb_fifo_stream_packetizer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_packetizer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_packetizer_pkg                                                 |
// | Shared types for the FIFO-to-AXI-stream packetizer.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_stream_packetizer_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_PRESENT = 2'd2
   } pk_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_timer                                                          |
// | Saturating idle counter with clear/enable and an expiry compare.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_stream_timer #(
   parameter int LGTMO = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [LGTMO-1:0] i_timeout,
   output logic             o_expired
);

   logic [LGTMO-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != {LGTMO{1'b1}})) begin
         r_count <= r_count + LGTMO'(1);
      end
   end

   assign o_expired = (r_count >= i_timeout);

endmodule
`default_nettype wire

// File: rtl/fifo_stream_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_packetizer                                                     |
// | Drains an FWFT FIFO into an AXI-stream master, framing packets by length   |
// | or by idle timeout.                                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_stream_packetizer
   import fifo_stream_packetizer_pkg::*;
#(
   parameter int BW    = 8,
   parameter int LGPKT = 8,
   parameter int LGTMO = 8
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   output logic             o_rd,
   input  logic [BW-1:0]    i_data,
   input  logic             i_empty,
   input  logic [LGPKT-1:0] i_pkt_len,
   input  logic [LGTMO-1:0] i_timeout,
   output logic             M_AXIS_TVALID,
   input  logic             M_AXIS_TREADY,
   output logic [BW-1:0]    M_AXIS_TDATA,
   output logic             M_AXIS_TLAST,
   output logic             o_busy
);

   localparam int CW = LGPKT + 1;
   localparam logic [CW-1:0] c_len_max = CW'(1) << LGPKT;

   pk_state_t       r_state;
   pk_state_t       w_state_next;
   logic [BW-1:0]   r_head_data;
   logic [BW-1:0]   r_tail_data;
   logic            r_head_last;
   logic            r_tail_last;
   logic            r_tail_valid;
   logic            r_tlast;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_len;

   logic            w_head_valid;
   logic            w_committed;
   logic            w_flush;
   logic            w_timer_en;
   logic            w_pop;
   logic            w_capture;
   logic            w_flush_commit;
   logic            w_tlast_now;
   logic [CW-1:0]   w_cnt_base;
   logic [CW-1:0]   w_len_in;
   logic [CW-1:0]   w_len_cur;
   logic            w_tag;
   logic            w_head_valid_next;
   logic            w_commit_next;

   assign w_head_valid = (r_state != ST_EMPTY);
   assign w_committed  = (r_state == ST_PRESENT);

   assign w_timer_en = w_head_valid && !r_tail_valid && !r_head_last
                     && !w_committed && i_empty;

   fifo_stream_timer #(
      .LGTMO (LGTMO)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   (!w_timer_en),
      .i_enable  (w_timer_en),
      .i_timeout (i_timeout),
      .o_expired (w_flush)
   );

   assign M_AXIS_TVALID = w_head_valid
                        && (w_committed || r_head_last || r_tail_valid || w_flush);
   assign w_tlast_now   = r_head_last || (!r_tail_valid && w_flush);
   assign M_AXIS_TLAST  = w_committed ? r_tlast : (M_AXIS_TVALID && w_tlast_now);
   assign M_AXIS_TDATA  = r_head_data;

   assign w_pop     = M_AXIS_TVALID && M_AXIS_TREADY;
   assign o_rd      = i_reset_n && !i_empty && (!r_tail_valid || w_pop);
   assign w_capture = o_rd;

   // A flush-caused commit restarts the count before any same-cycle capture is tagged.
   assign w_flush_commit = M_AXIS_TVALID && !w_committed && !r_head_last
                         && !r_tail_valid && w_flush;
   assign w_cnt_base     = w_flush_commit ? '0 : r_cnt;
   assign w_len_in       = (i_pkt_len == '0) ? c_len_max : {1'b0, i_pkt_len};
   assign w_len_cur      = (w_cnt_base == '0) ? w_len_in : r_len;
   assign w_tag          = (w_cnt_base == (w_len_cur - CW'(1)));

   assign o_busy = w_head_valid || r_tail_valid || (r_cnt != '0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_head_valid_next = w_head_valid;
      w_commit_next     = 1'b0;
      w_state_next      = r_state;
      if (w_pop) begin
         w_head_valid_next = r_tail_valid || w_capture;
      end else begin
         w_head_valid_next = w_head_valid || w_capture;
         w_commit_next     = M_AXIS_TVALID;
      end
      if (!w_head_valid_next) begin
         w_state_next = ST_EMPTY;
      end else if (w_commit_next) begin
         w_state_next = ST_PRESENT;
      end else begin
         w_state_next = ST_HOLD;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_head_data  <= '0;
         r_head_last  <= 1'b0;
         r_tail_data  <= '0;
         r_tail_last  <= 1'b0;
         r_tail_valid <= 1'b0;
         r_tlast      <= 1'b0;
         r_cnt        <= '0;
         r_len        <= '0;
      end else begin
         if (w_pop) begin
            if (r_tail_valid) begin
               r_head_data <= r_tail_data;
               r_head_last <= r_tail_last;
            end else if (w_capture) begin
               r_head_data <= i_data;
               r_head_last <= w_tag;
            end
            r_tail_valid <= r_tail_valid && w_capture;
            if (r_tail_valid && w_capture) begin
               r_tail_data <= i_data;
               r_tail_last <= w_tag;
            end
         end else if (w_capture) begin
            if (!w_head_valid) begin
               r_head_data <= i_data;
               r_head_last <= w_tag;
            end else begin
               r_tail_data  <= i_data;
               r_tail_last  <= w_tag;
               r_tail_valid <= 1'b1;
            end
         end

         if (M_AXIS_TVALID && !w_committed) begin
            r_tlast <= w_tlast_now;
         end

         if (w_capture) begin
            r_cnt <= w_tag ? '0 : (w_cnt_base + CW'(1));
            if (w_cnt_base == '0) begin
               r_len <= w_len_in;
            end
         end else begin
            r_cnt <= w_cnt_base;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_packetizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_stream_packetizer                                                  |
// | Directed bench: FIFO model feeding the packetizer, stream beats collected. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_stream_packetizer;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       o_rd;
   logic [7:0] i_data = 8'h00;
   logic       i_empty = 1'b1;
   logic [7:0] i_pkt_len = 8'd4;
   logic [7:0] i_timeout = 8'd255;
   logic       M_AXIS_TVALID;
   logic       M_AXIS_TREADY = 1'b0;
   logic [7:0] M_AXIS_TDATA;
   logic       M_AXIS_TLAST;
   logic       o_busy;

   logic [7:0] fifo_q[$];
   logic [7:0] out_data[$];
   logic       out_last[$];
   int         out_cyc[$];
   int         cyc = 0;
   int         rd_count = 0;
   logic       rd_pend = 1'b0;
   int         n_err = 0;
   int         n_chk = 0;

   fifo_stream_packetizer #(
      .BW    (8),
      .LGPKT (8),
      .LGTMO (8)
   ) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .o_rd          (o_rd),
      .i_data        (i_data),
      .i_empty       (i_empty),
      .i_pkt_len     (i_pkt_len),
      .i_timeout     (i_timeout),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .o_busy        (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      i_empty = (fifo_q.size() == 0);
      i_data  = i_empty ? 8'h00 : fifo_q[0];
   endtask

   // Handshakes are sampled mid-cycle; inputs change just after the rising edge.
   always @(negedge i_clk) begin
      cyc++;
      rd_pend = o_rd;
      if (o_rd) rd_count++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
         out_data.push_back(M_AXIS_TDATA);
         out_last.push_back(M_AXIS_TLAST);
         out_cyc.push_back(cyc);
      end
   end

   always @(posedge i_clk) begin
      #1;
      if (rd_pend && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
      rd_pend = 1'b0;
      refresh();
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #2;
   endtask

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      refresh();
   endtask

   task automatic clear_out();
      out_data.delete();
      out_last.delete();
      out_cyc.delete();
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k;
      k = 0;
      while ((out_data.size() < n) && (k < budget)) begin
         tick(1);
         k++;
      end
      if (out_data.size() < n) check("beat_wait_expired", out_data.size(), n);
   endtask

   task automatic expect_seq(input string tag, input int n, input logic [7:0] base,
                             input logic [15:0] last_mask);
      check({tag, "_count"}, out_data.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < out_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), out_data[i], base + 8'(i));
            check($sformatf("%s_last%0d", tag, i), out_last[i], last_mask[i]);
         end
      end
   endtask

   initial begin
      int bad;
      int nlast;
      int rd0;
      int unstable;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;
      int nlast;
      int rd0;
      int unstable;

      // Reset state, with a word waiting in the FIFO
      push(8'h55);
      tick(3);
      check("rst_tvalid", M_AXIS_TVALID, 0);
      check("rst_tlast", M_AXIS_TLAST, 0);
      check("rst_tdata", M_AXIS_TDATA, 0);
      check("rst_busy", o_busy, 0);
      check("rst_rd", o_rd, 0);
      fifo_q.delete();
      refresh();
      tick(1);
      i_reset_n = 1'b1;
      tick(2);

      // Length framing, back-to-back beats
      M_AXIS_TREADY = 1'b1; i_pkt_len = 8'd4; i_timeout = 8'd255;
      clear_out();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      wait_beats(8, 50);
      expect_seq("t1", 8, 8'h10, 16'b1000_1000);
      check("t1_span", out_cyc[7] - out_cyc[0], 7);

      // Idle-timeout close of a partial packet, then fresh count
      i_timeout = 8'd3;
      clear_out();
      push(8'hA0); push(8'hA1);
      wait_beats(2, 30);
      expect_seq("t2a", 2, 8'hA0, 16'b10);
      check("t2_gap", out_cyc[1] - out_cyc[0], 4);
      clear_out();
      for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
      wait_beats(4, 30);
      expect_seq("t2b", 4, 8'hB0, 16'b1000);

      // Length 0 means 256 beats; trailing partial closes by timeout
      i_pkt_len = 8'd0; i_timeout = 8'd255;
      clear_out();
      for (int i = 0; i < 300; i++) push(8'(i));
      wait_beats(300, 1200);
      bad = 0; nlast = 0;
      for (int i = 0; i < out_data.size(); i++) begin
         if (out_data[i] != 8'(i)) bad++;
         if (out_last[i] != ((i == 255) || (i == 299))) bad++;
         if (out_last[i]) nlast++;
      end
      check("t3_bad_beats", bad, 0);
      check("t3_last255", out_last[255], 1);
      check("t3_nlast", nlast, 2);

      // Backpressure with 5 words queued
      M_AXIS_TREADY = 1'b0; i_pkt_len = 8'd5;
      clear_out();
      rd0 = rd_count;
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
      unstable = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (M_AXIS_TVALID && ((M_AXIS_TDATA != 8'hC0) || M_AXIS_TLAST)) unstable++;
      end
      check("t4_reads", rd_count - rd0, 2);
      check("t4_fifo_left", fifo_q.size(), 3);
      check("t4_tvalid", M_AXIS_TVALID, 1);
      check("t4_unstable", unstable, 0);
      check("t4_no_beats", out_data.size(), 0);
      M_AXIS_TREADY = 1'b1;
      wait_beats(5, 30);
      expect_seq("t4", 5, 8'hC0, 16'b10000);

      // Flush commit held under backpressure while a new word arrives
      M_AXIS_TREADY = 1'b0; i_pkt_len = 8'd4; i_timeout = 8'd2;
      clear_out();
      push(8'hD0);
      tick(8);
      check("t5_tvalid", M_AXIS_TVALID, 1);
      check("t5_tlast", M_AXIS_TLAST, 1);
      push(8'hD1);
      tick(3);
      check("t5_tlast_kept", M_AXIS_TLAST, 1);
      check("t5_tdata_kept", M_AXIS_TDATA, 8'hD0);
      check("t5_fifo_drained", fifo_q.size(), 0);
      push(8'hD2); push(8'hD3); push(8'hD4);
      M_AXIS_TREADY = 1'b1;
      wait_beats(5, 30);
      expect_seq("t5", 5, 8'hD0, 16'b10001);

      // Zero timeout closes at once
      i_timeout = 8'd0;
      clear_out();
      push(8'h60);
      wait_beats(1, 10);
      expect_seq("t6", 1, 8'h60, 16'b1);

      // One-beat packets
      i_pkt_len = 8'd1; i_timeout = 8'd255;
      clear_out();
      push(8'h70); push(8'h71); push(8'h72);
      wait_beats(3, 20);
      expect_seq("t7", 3, 8'h70, 16'b111);

      // Asynchronous reset mid-packet
      M_AXIS_TREADY = 1'b0; i_pkt_len = 8'd4;
      clear_out();
      push(8'hE0); push(8'hE1);
      tick(4);
      check("t8_pre_tvalid", M_AXIS_TVALID, 1);
      check("t8_pre_busy", o_busy, 1);
      i_reset_n = 1'b0;
      #1;
      check("t8_tvalid", M_AXIS_TVALID, 0);
      check("t8_tlast", M_AXIS_TLAST, 0);
      check("t8_busy", o_busy, 0);
      check("t8_tdata", M_AXIS_TDATA, 0);
      tick(2);
      i_reset_n = 1'b1;
      tick(1);
      clear_out();
      M_AXIS_TREADY = 1'b1;
      for (int i = 0; i < 4; i++) push(8'hF0 + 8'(i));
      wait_beats(4, 30);
      expect_seq("t8", 4, 8'hF0, 16'b1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
